// File: rtl/interrupt_request_service_unit.sv
// IRR / priority resolver / ISR core of an 8259A-style interrupt controller.
// Captures IR pins, resolves the rotating-priority winner and tracks in-service levels.
module interrupt_request_service_unit #(
  parameter int NUM_IR = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt_request_pin,
  input  logic       level_or_edge_triggered_config,
  input  logic       special_fully_nest_config,
  input  logic       write_initial_command_word_1,
  input  logic       freeze,
  input  logic [7:0] clear_interrupt_request,
  input  logic [7:0] interrupt_mask,
  input  logic [7:0] interrupt_special_mask,
  input  logic [2:0] priority_rotate,
  input  logic       latch_in_service,
  input  logic [7:0] end_of_interrupt,
  output logic [7:0] interrupt,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] in_service_register
);

  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] prev_pin;
  logic [7:0] interrupt_q;

  logic [7:0] set_term;
  logic [7:0] irr_next;
  logic [7:0] req;
  logic [7:0] blk;
  logic [7:0] candidate;
  logic [7:0] blk_top;
  logic [7:0] winner;
  logic [2:0] shift;
  logic [2:0] cand_dist;
  logic [2:0] blk_dist;

  function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] lowest_one(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 8'h01 << i;
    end
    return r;
  endfunction

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Highest-priority bit: rotate so level (rotate+1) sits at bit 0, pick the lowest, rotate back.
  function automatic logic [7:0] resolve(input logic [7:0] v, input logic [2:0] n);
    return rotate_left(lowest_one(rotate_right(v, n)), n);
  endfunction

  always_comb begin
    shift = priority_rotate + 3'd1;
    set_term = level_or_edge_triggered_config ? interrupt_request_pin
                                              : (interrupt_request_pin & ~prev_pin);
    for (int i = 0; i < 8; i++) begin
      if (clear_interrupt_request[i])
        irr_next[i] = 1'b0;
      else if (freeze)
        irr_next[i] = irr[i];
      else if (level_or_edge_triggered_config)
        irr_next[i] = interrupt_request_pin[i];
      else
        irr_next[i] = irr[i] | set_term[i];
    end
  end

  always_comb begin
    req       = irr & ~interrupt_mask;
    blk       = isr & ~interrupt_special_mask;
    candidate = resolve(req, shift);
    blk_top   = resolve(blk, shift);
    // Distance from the highest-priority level; smaller means more urgent.
    cand_dist = encode(candidate) - priority_rotate - 3'd1;
    blk_dist  = encode(blk_top) - priority_rotate - 3'd1;
    winner    = 8'h00;
    if (candidate != 8'h00) begin
      if (blk == 8'h00 || cand_dist < blk_dist ||
          (special_fully_nest_config && cand_dist == blk_dist))
        winner = candidate;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irr         <= 8'h00;
      isr         <= 8'h00;
      prev_pin    <= 8'hFF;
      interrupt_q <= 8'h00;
    end else if (write_initial_command_word_1) begin
      irr         <= 8'h00;
      isr         <= 8'h00;
      prev_pin    <= 8'hFF;
      interrupt_q <= 8'h00;
    end else begin
      irr      <= irr_next;
      prev_pin <= interrupt_request_pin;
      isr      <= (isr & ~end_of_interrupt) | (latch_in_service ? interrupt_q : 8'h00);
      if (!freeze) interrupt_q <= winner;
    end
  end

  assign interrupt                  = interrupt_q;
  assign highest_level_in_service   = blk_top;
  assign interrupt_request_register = irr;
  assign in_service_register        = isr;

endmodule

// File: tb/tb_interrupt_request_service_unit.sv
// Directed bench for interrupt_request_service_unit: edge/level capture, masking,
// rotation, in-service blocking, special modes, ICW1 and asynchronous reset.
module tb_interrupt_request_service_unit;

  logic       clock;
  logic       reset;
  logic [7:0] interrupt_request_pin;
  logic       level_or_edge_triggered_config;
  logic       special_fully_nest_config;
  logic       write_initial_command_word_1;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] interrupt_mask;
  logic [7:0] interrupt_special_mask;
  logic [2:0] priority_rotate;
  logic       latch_in_service;
  logic [7:0] end_of_interrupt;
  logic [7:0] interrupt;
  logic [7:0] highest_level_in_service;
  logic [7:0] interrupt_request_register;
  logic [7:0] in_service_register;

  int checks;
  int failures;

  interrupt_request_service_unit dut (
    .clock                          (clock),
    .reset                          (reset),
    .interrupt_request_pin          (interrupt_request_pin),
    .level_or_edge_triggered_config (level_or_edge_triggered_config),
    .special_fully_nest_config      (special_fully_nest_config),
    .write_initial_command_word_1   (write_initial_command_word_1),
    .freeze                         (freeze),
    .clear_interrupt_request        (clear_interrupt_request),
    .interrupt_mask                 (interrupt_mask),
    .interrupt_special_mask         (interrupt_special_mask),
    .priority_rotate                (priority_rotate),
    .latch_in_service               (latch_in_service),
    .end_of_interrupt               (end_of_interrupt),
    .interrupt                      (interrupt),
    .highest_level_in_service       (highest_level_in_service),
    .interrupt_request_register     (interrupt_request_register),
    .in_service_register            (in_service_register)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic cleanup();
    interrupt_request_pin   = 8'h00;
    clear_interrupt_request = 8'hFF;
    end_of_interrupt        = 8'hFF;
    step();
    clear_interrupt_request = 8'h00;
    end_of_interrupt        = 8'h00;
    step();
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    interrupt_request_pin          = 8'h00;
    level_or_edge_triggered_config = 1'b0;
    special_fully_nest_config      = 1'b0;
    write_initial_command_word_1   = 1'b0;
    freeze                         = 1'b0;
    clear_interrupt_request        = 8'h00;
    interrupt_mask                 = 8'h00;
    interrupt_special_mask         = 8'h00;
    priority_rotate                = 3'd7;
    latch_in_service               = 1'b0;
    end_of_interrupt               = 8'h00;

    repeat (2) step();
    check("reset_irr", interrupt_request_register, 8'h00);
    check("reset_isr", in_service_register, 8'h00);
    check("reset_int", interrupt, 8'h00);
    check("reset_hlis", highest_level_in_service, 8'h00);
    reset = 1'b0;
    step();

    // Edge capture and default priority
    interrupt_request_pin = 8'h24;
    step();
    check("edge_irr", interrupt_request_register, 8'h24);
    check("edge_int_latency", interrupt, 8'h00);
    step();
    check("edge_int", interrupt, 8'h04);
    clear_interrupt_request = 8'h04;
    step();
    clear_interrupt_request = 8'h00;
    step();
    check("held_pin_no_reset", interrupt_request_register, 8'h20);
    check("held_pin_int", interrupt, 8'h20);
    cleanup();

    // Masking and rotation
    interrupt_request_pin = 8'h81;
    interrupt_mask = 8'h01;
    step();
    check("mask_irr", interrupt_request_register, 8'h81);
    step();
    check("mask_int", interrupt, 8'h80);
    interrupt_mask = 8'h00;
    priority_rotate = 3'd0;
    step();
    check("rotate0_int", interrupt, 8'h80);
    priority_rotate = 3'd7;
    step();
    check("rotate7_int", interrupt, 8'h01);
    cleanup();

    // In-service blocking
    interrupt_request_pin = 8'h08;
    step();
    step();
    latch_in_service = 1'b1;
    clear_interrupt_request = 8'h08;
    step();
    latch_in_service = 1'b0;
    clear_interrupt_request = 8'h00;
    check("latch_isr", in_service_register, 8'h08);
    check("latch_hlis", highest_level_in_service, 8'h08);
    interrupt_request_pin = 8'h28;
    step();
    step();
    check("blocked_ir5", interrupt, 8'h00);
    interrupt_request_pin = 8'h2A;
    step();
    step();
    check("ir1_preempts", interrupt, 8'h02);
    clear_interrupt_request = 8'h02;
    end_of_interrupt = 8'h08;
    step();
    clear_interrupt_request = 8'h00;
    end_of_interrupt = 8'h00;
    check("eoi_isr", in_service_register, 8'h00);
    step();
    check("eoi_ir5_wins", interrupt, 8'h20);
    cleanup();

    // Special fully nested mode
    interrupt_request_pin = 8'h08;
    step();
    step();
    latch_in_service = 1'b1;
    step();
    latch_in_service = 1'b0;
    step();
    check("sfnm0_int", interrupt, 8'h00);
    special_fully_nest_config = 1'b1;
    step();
    check("sfnm1_int", interrupt, 8'h08);
    special_fully_nest_config = 1'b0;
    cleanup();

    // Special mask
    interrupt_request_pin = 8'h01;
    step();
    step();
    latch_in_service = 1'b1;
    clear_interrupt_request = 8'h01;
    step();
    latch_in_service = 1'b0;
    clear_interrupt_request = 8'h00;
    check("smask_isr", in_service_register, 8'h01);
    interrupt_special_mask = 8'h01;
    interrupt_request_pin = 8'h41;
    step();
    step();
    check("smask_int", interrupt, 8'h40);
    check("smask_hlis", highest_level_in_service, 8'h00);
    interrupt_special_mask = 8'h00;
    step();
    check("smask_off_int", interrupt, 8'h00);
    cleanup();

    // Level mode, freeze, clear
    level_or_edge_triggered_config = 1'b1;
    interrupt_request_pin = 8'h10;
    step();
    check("level_irr", interrupt_request_register, 8'h10);
    interrupt_request_pin = 8'h00;
    step();
    check("level_drop_irr", interrupt_request_register, 8'h00);
    interrupt_request_pin = 8'h10;
    step();
    step();
    check("level_int", interrupt, 8'h10);
    freeze = 1'b1;
    interrupt_request_pin = 8'h00;
    step();
    check("freeze_irr", interrupt_request_register, 8'h10);
    check("freeze_int", interrupt, 8'h10);
    freeze = 1'b0;
    step();
    check("unfreeze_irr", interrupt_request_register, 8'h00);
    level_or_edge_triggered_config = 1'b0;
    interrupt_request_pin = 8'h10;
    clear_interrupt_request = 8'h10;
    step();
    clear_interrupt_request = 8'h00;
    check("clear_wins", interrupt_request_register, 8'h00);
    step();
    check("clear_no_reedge", interrupt_request_register, 8'h00);
    cleanup();

    // ICW1 reinitialisation with IRR=F0, ISR=0F
    interrupt_special_mask = 8'hFF;
    interrupt_request_pin = 8'h0F;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      latch_in_service = 1'b1;
      clear_interrupt_request = 8'h01 << i;
      step();
      latch_in_service = 1'b0;
      clear_interrupt_request = 8'h00;
      step();
    end
    interrupt_request_pin = 8'hFF;
    step();
    check("pre_icw1_irr", interrupt_request_register, 8'hF0);
    check("pre_icw1_isr", in_service_register, 8'h0F);
    step();
    check("pre_icw1_int", interrupt, 8'h10);
    write_initial_command_word_1 = 1'b1;
    step();
    write_initial_command_word_1 = 1'b0;
    check("icw1_irr", interrupt_request_register, 8'h00);
    check("icw1_isr", in_service_register, 8'h00);
    check("icw1_int", interrupt, 8'h00);
    step();
    check("icw1_no_edge", interrupt_request_register, 8'h00);
    interrupt_special_mask = 8'h00;
    cleanup();

    // Asynchronous reset between edges
    interrupt_request_pin = 8'h04;
    step();
    step();
    check("pre_reset_int", interrupt, 8'h04);
    #2 reset = 1'b1;
    #1;
    check("async_irr", interrupt_request_register, 8'h00);
    check("async_int", interrupt, 8'h00);
    check("async_isr", in_service_register, 8'h00);
    #2 reset = 1'b0;
    step();
    check("post_reset_irr", interrupt_request_register, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
